// File: rtl/div_exec_unit.sv
// Multi-cycle radix-2 restoring integer divider for the DIV/DIVU issue port.
// Holds each result on the CDB request until the arbiter grants it.
module div_exec_unit #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [DATA_W-1:0] issue_rsdata,
  input  logic [DATA_W-1:0] issue_rtdata,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic              issue_signed,
  input  logic              issue_rem,
  input  logic              flush,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic              cdb_valid,
  output logic [DATA_W-1:0] cdb_data,
  output logic [TAG_W-1:0]  cdb_tag
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state, w_state_nx;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_cdb_req;
  logic [DATA_W-1:0]   r_cdb_data;
  logic [TAG_W-1:0]    r_cdb_tag;

  logic [DATA_W-1:0]   r_rem, r_quo, r_dvs;
  logic [TAG_W-1:0]    r_tag;
  logic                r_rem_sel, r_neg_q, r_neg_r, r_dvz;

  logic                w_accept, w_last_step, w_ge;
  logic                w_rs_neg, w_rt_neg;
  logic [DATA_W-1:0]   w_rs_mag, w_rt_mag;
  logic [DATA_W:0]     w_shift, w_trial;
  logic [DATA_W-1:0]   w_rem_nx, w_quo_nx, w_q_fin, w_r_fin, w_result;

  assign issue_ready = ~flush & ((r_state == S_IDLE) | ((r_state == S_DONE) & cdb_grant));
  assign w_accept    = issue_valid & issue_ready;
  assign w_last_step = (r_state == S_BUSY) & (r_cnt == LAST_STEP) & ~flush;

  assign w_rs_neg = issue_signed & issue_rsdata[DATA_W-1];
  assign w_rt_neg = issue_signed & issue_rtdata[DATA_W-1];
  assign w_rs_mag = w_rs_neg ? -issue_rsdata : issue_rsdata;
  assign w_rt_mag = w_rt_neg ? -issue_rtdata : issue_rtdata;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and keep the difference only if it did not borrow.
  assign w_shift  = {r_rem, r_quo[DATA_W-1]};
  assign w_trial  = w_shift - {1'b0, r_dvs};
  assign w_ge     = ~w_trial[DATA_W];
  assign w_rem_nx = w_ge ? w_trial[DATA_W-1:0] : w_shift[DATA_W-1:0];
  assign w_quo_nx = {r_quo[DATA_W-2:0], w_ge};

  // Divide-by-zero forces an all-ones quotient even when the sign fix-up
  // would otherwise negate it; the remainder already equals the dividend.
  assign w_q_fin  = r_dvz ? '1 : (r_neg_q ? -w_quo_nx : w_quo_nx);
  assign w_r_fin  = r_neg_r ? -w_rem_nx : w_rem_nx;
  assign w_result = r_rem_sel ? w_r_fin : w_q_fin;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nx = S_BUSY;
      S_BUSY:  if (r_cnt == LAST_STEP) w_state_nx = S_DONE;
      S_DONE:  if (cdb_grant) w_state_nx = w_accept ? S_BUSY : S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    if (flush) w_state_nx = S_IDLE;
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cdb_req  <= 1'b0;
      r_cdb_data <= '0;
      r_cdb_tag  <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cdb_req <= (w_state_nx == S_DONE);
      if (w_accept)
        r_cnt <= '0;
      else if (r_state == S_BUSY)
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_last_step) begin
        r_cdb_data <= w_result;
        r_cdb_tag  <= r_tag;
      end
    end
  end

  // NOTE: the arithmetic datapath is left unreset; it is always reloaded on
  // accept before being consumed, and the control registers gate its use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rem     <= '0;
      r_quo     <= w_rs_mag;
      r_dvs     <= w_rt_mag;
      r_tag     <= issue_tag;
      r_rem_sel <= issue_rem;
      r_neg_q   <= w_rs_neg ^ w_rt_neg;
      r_neg_r   <= w_rs_neg;
      r_dvz     <= (issue_rtdata == '0);
    end else if (r_state == S_BUSY) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
    end
  end

  assign cdb_req   = r_cdb_req;
  assign cdb_valid = r_cdb_req & cdb_grant & ~flush;
  assign cdb_data  = r_cdb_data;
  assign cdb_tag   = r_cdb_tag;

endmodule

// File: tb/tb_div_exec_unit.sv
// Directed self-checking bench for div_exec_unit: latency, signed/unsigned
// arithmetic corners, CDB hold/grant, flush and mid-operation reset.
module tb_div_exec_unit;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;

  logic              clk;
  logic              rst;
  logic              issue_valid;
  logic              issue_ready;
  logic [DATA_W-1:0] issue_rsdata;
  logic [DATA_W-1:0] issue_rtdata;
  logic [TAG_W-1:0]  issue_tag;
  logic              issue_signed;
  logic              issue_rem;
  logic              flush;
  logic              cdb_req;
  logic              cdb_grant;
  logic              cdb_valid;
  logic [DATA_W-1:0] cdb_data;
  logic [TAG_W-1:0]  cdb_tag;

  int n_checks = 0;
  int n_errors = 0;

  div_exec_unit #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_rsdata (issue_rsdata),
    .issue_rtdata (issue_rtdata),
    .issue_tag    (issue_tag),
    .issue_signed (issue_signed),
    .issue_rem    (issue_rem),
    .flush        (flush),
    .cdb_req      (cdb_req),
    .cdb_grant    (cdb_grant),
    .cdb_valid    (cdb_valid),
    .cdb_data     (cdb_data),
    .cdb_tag      (cdb_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_op(input logic [31:0] rs, input logic [31:0] rt,
                          input logic [5:0] tg, input logic sgn, input logic rem);
    issue_valid  = 1'b1;
    issue_rsdata = rs;
    issue_rtdata = rt;
    issue_tag    = tg;
    issue_signed = sgn;
    issue_rem    = rem;
  endtask

  // Called at the negedge right after the accept edge; returns the cycle
  // count from the issue cycle to the first cycle with cdb_req high.
  task automatic wait_req(output int n);
    issue_valid = 1'b0;
    n = 1;
    while (cdb_req !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [5:0] tg, input logic sgn, input logic rem,
                        input logic [31:0] exp);
    int n;
    tick();
    drive_op(rs, rt, tg, sgn, rem);
    #1 check({name, " ready"}, 32'(issue_ready), 32'd1);
    tick();
    wait_req(n);
    check({name, " latency"}, 32'(n), 32'd33);
    cdb_grant = 1'b1;
    #1;
    check({name, " valid"}, 32'(cdb_valid), 32'd1);
    check({name, " data"}, cdb_data, exp);
    check({name, " tag"}, 32'(cdb_tag), 32'(tg));
    tick();
    cdb_grant = 1'b0;
    #1;
    check({name, " req_drop"}, 32'(cdb_req), 32'd0);
    check({name, " idle_ready"}, 32'(issue_ready), 32'd1);
  endtask

  initial begin
    int n;
    int highs;
    rst = 1'b1;
    flush = 1'b0;
    cdb_grant = 1'b0;
    issue_valid = 1'b0;
    issue_rsdata = '0;
    issue_rtdata = '0;
    issue_tag = '0;
    issue_signed = 1'b0;
    issue_rem = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst req", 32'(cdb_req), 32'd0);
    check("rst valid", 32'(cdb_valid), 32'd0);
    check("rst data", cdb_data, 32'd0);
    check("rst tag", 32'(cdb_tag), 32'd0);
    check("rst ready", 32'(issue_ready), 32'd1);

    // Basic unsigned divide with latency check.
    run_op("divu_100_7", 32'd100, 32'd7, 6'd5, 1'b0, 1'b0, 32'd14);

    // Signed quotient/remainder sign handling.
    run_op("div_m7_2_q", 32'hFFFF_FFF9, 32'd2, 6'd1, 1'b1, 1'b0, 32'hFFFF_FFFD);
    run_op("div_m7_2_r", 32'hFFFF_FFF9, 32'd2, 6'd2, 1'b1, 1'b1, 32'hFFFF_FFFF);
    run_op("div_100_m7_q", 32'd100, 32'hFFFF_FFF9, 6'd3, 1'b1, 1'b0, 32'hFFFF_FFF2);
    run_op("div_100_m7_r", 32'd100, 32'hFFFF_FFF9, 6'd4, 1'b1, 1'b1, 32'd2);

    // Divide by zero and signed overflow.
    run_op("divu_dz_q", 32'h0000_1234, 32'd0, 6'd6, 1'b0, 1'b0, 32'hFFFF_FFFF);
    run_op("divu_dz_r", 32'h0000_1234, 32'd0, 6'd7, 1'b0, 1'b1, 32'h0000_1234);
    run_op("div_dz_neg_q", 32'hFFFF_FFFB, 32'd0, 6'd8, 1'b1, 1'b0, 32'hFFFF_FFFF);
    run_op("div_dz_neg_r", 32'hFFFF_FFFB, 32'd0, 6'd9, 1'b1, 1'b1, 32'hFFFF_FFFB);
    run_op("div_ovf_q", 32'h8000_0000, 32'hFFFF_FFFF, 6'd10, 1'b1, 1'b0, 32'h8000_0000);
    run_op("div_ovf_r", 32'h8000_0000, 32'hFFFF_FFFF, 6'd11, 1'b1, 1'b1, 32'd0);

    // Hold grant low for 5 cycles, then grant with a same-cycle accept.
    tick();
    drive_op(32'd50, 32'd5, 6'd12, 1'b0, 1'b0);
    tick();
    wait_req(n);
    check("hold latency", 32'(n), 32'd33);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold req", 32'(cdb_req), 32'd1);
      check("hold data", cdb_data, 32'd10);
      check("hold tag", 32'(cdb_tag), 32'd12);
      check("hold ready", 32'(issue_ready), 32'd0);
      check("hold valid", 32'(cdb_valid), 32'd0);
      tick();
    end
    cdb_grant = 1'b1;
    drive_op(32'd81, 32'd9, 6'd13, 1'b0, 1'b0);
    #1;
    check("b2b valid", 32'(cdb_valid), 32'd1);
    check("b2b ready", 32'(issue_ready), 32'd1);
    check("b2b data", cdb_data, 32'd10);
    tick();
    cdb_grant = 1'b0;
    wait_req(n);
    check("b2b latency", 32'(n), 32'd33);
    check("b2b new data", cdb_data, 32'd9);
    check("b2b new tag", 32'(cdb_tag), 32'd13);
    cdb_grant = 1'b1;
    #1 check("b2b new valid", 32'(cdb_valid), 32'd1);
    tick();
    cdb_grant = 1'b0;

    // Flush while BUSY at cnt=10.
    drive_op(32'd1000, 32'd3, 6'd14, 1'b0, 1'b0);
    tick();
    issue_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    #1;
    check("flush_busy ready", 32'(issue_ready), 32'd0);
    check("flush_busy valid", 32'(cdb_valid), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_busy req", 32'(cdb_req), 32'd0);
    check("flush_busy idle", 32'(issue_ready), 32'd1);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cdb_req === 1'b1) highs++;
    end
    check("flush_busy no_req", 32'(highs), 32'd0);
    check("flush_busy data_kept", cdb_data, 32'd9);
    run_op("post_flush_busy", 32'd1000, 32'd3, 6'd15, 1'b0, 1'b1, 32'd1);

    // Flush in DONE with grant high and a competing issue.
    tick();
    drive_op(32'd77, 32'd7, 6'd16, 1'b0, 1'b0);
    tick();
    wait_req(n);
    check("flush_done latency", 32'(n), 32'd33);
    cdb_grant = 1'b1;
    flush = 1'b1;
    drive_op(32'd8, 32'd2, 6'd17, 1'b0, 1'b0);
    #1;
    check("flush_done valid", 32'(cdb_valid), 32'd0);
    check("flush_done ready", 32'(issue_ready), 32'd0);
    tick();
    cdb_grant = 1'b0;
    flush = 1'b0;
    issue_valid = 1'b0;
    #1;
    check("flush_done req", 32'(cdb_req), 32'd0);
    check("flush_done idle", 32'(issue_ready), 32'd1);
    check("flush_done data_kept", cdb_data, 32'd11);
    run_op("post_flush_done", 32'd8, 32'd2, 6'd18, 1'b0, 1'b0, 32'd4);

    // Reset in the middle of BUSY.
    tick();
    drive_op(32'd500, 32'd4, 6'd19, 1'b0, 1'b0);
    tick();
    issue_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst req", 32'(cdb_req), 32'd0);
    check("mid_rst valid", 32'(cdb_valid), 32'd0);
    check("mid_rst data", cdb_data, 32'd0);
    check("mid_rst tag", 32'(cdb_tag), 32'd0);
    check("mid_rst ready", 32'(issue_ready), 32'd1);
    run_op("post_rst_9_3", 32'd9, 32'd3, 6'd20, 1'b0, 1'b0, 32'd3);

    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
